muldiv_sequencer: RTL



---
 rtl/alu_pkg.sv | 24 ++
 rtl/muldiv_step.sv | 71 +++++++
 rtl/muldiv_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode constants used by the ALU decoder and the
// multi-cycle Mul/Div sequencer, the sequencer state encoding, and the
// datapath width.
package alu_pkg;

  localparam int WIDTH = 32;

  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Magnitude of a two's complement value as unsigned; the most negative
  // value maps onto itself, which is exactly its unsigned magnitude.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the Mul/Div datapath.
// Mul: radix-2 Booth add/subtract on {mplr[0], q} followed by an arithmetic
//      right shift of {acc, mplr, q}.
// Div: restoring step on magnitudes, {rem, quo} shifted left, trial subtract
//      of the divisor magnitude in opnd. rem lives in acc[WIDTH-1:0].
// The divide path exists only when MULDIV_DIV_EN is defined.
module muldiv_step
  import alu_pkg::*;
(
`ifdef MULDIV_DIV_EN
  input  logic             is_div,
`endif
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] mplr,
  input  logic             q,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] mplr_next,
  output logic             q_next
);

  logic [WIDTH:0] booth_sum;

  // Booth recoding: add or subtract the sign-extended multiplicand
  always_comb begin
    case ({mplr[0], q})
      2'b01:   booth_sum = acc + {opnd[WIDTH-1], opnd};
      2'b10:   booth_sum = acc - {opnd[WIDTH-1], opnd};
      default: booth_sum = acc;
    endcase
  end

`ifdef MULDIV_DIV_EN
  // Remainder stays below the divisor magnitude (<= 2^31), so the shifted
  // partial remainder always fits in WIDTH bits.
  logic [WIDTH-1:0] shifted;
  logic [WIDTH:0]   trial;

  // Restoring trial subtraction of the divisor magnitude
  always_comb begin
    shifted = {acc[WIDTH-2:0], mplr[WIDTH-1]};
    trial   = {1'b0, shifted} - {1'b0, opnd};
  end

  // Select the iteration result for the current operation
  always_comb begin
    if (is_div) begin
      q_next = 1'b0;
      if (!trial[WIDTH]) begin
        acc_next  = {1'b0, trial[WIDTH-1:0]};
        mplr_next = {mplr[WIDTH-2:0], 1'b1};
      end else begin
        acc_next  = {1'b0, shifted};
        mplr_next = {mplr[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
      mplr_next = {booth_sum[0], mplr[WIDTH-1:1]};
      q_next    = mplr[0];
    end
  end
`else
  // Arithmetic right shift of the Booth register
  always_comb begin
    acc_next  = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    mplr_next = {booth_sum[0], mplr[WIDTH-1:1]};
    q_next    = mplr[0];
  end
`endif

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle Mul/Div controller for the ALU. Holds the iteration registers,
// the counter and the IDLE/RUN/FIX/DONE state machine; one muldiv_step does
// the arithmetic for each RUN cycle. HI/LO only change when done is raised.
// Build option: MULDIV_DIV_EN enables the Div opcode; without it Div starts
// are ignored and div_by_zero is constant 0.
module muldiv_sequencer
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH:0]   acc_reg;
  logic [WIDTH-1:0] mplr_reg;
  logic             q_reg;
  logic [WIDTH-1:0] opnd_reg;   // multiplicand for Mul, |divisor| for Div
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;

  logic [WIDTH:0]   acc_next;
  logic [WIDTH-1:0] mplr_next;
  logic             q_next;

  logic             mul_req;
  assign mul_req = start && (opcode == OP_MUL);

`ifdef MULDIV_DIV_EN
  logic             is_div_reg;
  logic             rem_neg_reg;  // remainder takes the dividend's sign
  logic             quo_neg_reg;  // quotient negative when signs differ
  logic             dbz_reg;
  logic             div_req;
  assign div_req = start && (opcode == OP_DIV);
`endif

  muldiv_step u_step (
`ifdef MULDIV_DIV_EN
    .is_div    (is_div_reg),
`endif
    .acc       (acc_reg),
    .mplr      (mplr_reg),
    .q         (q_reg),
    .opnd      (opnd_reg),
    .acc_next  (acc_next),
    .mplr_next (mplr_next),
    .q_next    (q_next)
  );

  // Control FSM with iteration registers and registered outputs
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      acc_reg     <= '0;
      mplr_reg    <= '0;
      q_reg       <= 1'b0;
      opnd_reg    <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
`ifdef MULDIV_DIV_EN
      is_div_reg  <= 1'b0;
      rem_neg_reg <= 1'b0;
      quo_neg_reg <= 1'b0;
      dbz_reg     <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (mul_req) begin
            state_reg  <= RUN;
            busy_reg   <= 1'b1;
            count_reg  <= '0;
            acc_reg    <= '0;
            mplr_reg   <= B;
            q_reg      <= 1'b0;
            opnd_reg   <= A;
`ifdef MULDIV_DIV_EN
            is_div_reg <= 1'b0;
            dbz_reg    <= 1'b0;
          end else if (div_req) begin
            busy_reg   <= 1'b1;
            count_reg  <= '0;
            is_div_reg <= 1'b1;
            if (B == '0) begin
              // No iterations: publish the divide-by-zero result at once
              state_reg <= DONE;
              done_reg  <= 1'b1;
              hi_reg    <= A;
              lo_reg    <= '1;
              dbz_reg   <= 1'b1;
            end else begin
              state_reg   <= RUN;
              dbz_reg     <= 1'b0;
              acc_reg     <= '0;
              mplr_reg    <= abs_val(A);
              q_reg       <= 1'b0;
              opnd_reg    <= abs_val(B);
              rem_neg_reg <= A[WIDTH-1];
              quo_neg_reg <= A[WIDTH-1] ^ B[WIDTH-1];
            end
`endif
          end
        end
        RUN: begin
          acc_reg   <= acc_next;
          mplr_reg  <= mplr_next;
          q_reg     <= q_next;
          count_reg <= count_reg + 1'b1;
          if (count_reg == CW'(WIDTH - 1)) begin
            state_reg <= FIX;
          end
        end
        FIX: begin
`ifdef MULDIV_DIV_EN
          if (is_div_reg) begin
            hi_reg <= rem_neg_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
            lo_reg <= quo_neg_reg ? -mplr_reg : mplr_reg;
          end else begin
            hi_reg <= acc_reg[WIDTH-1:0];
            lo_reg <= mplr_reg;
          end
`else
          hi_reg <= acc_reg[WIDTH-1:0];
          lo_reg <= mplr_reg;
`endif
          done_reg  <= 1'b1;
          state_reg <= DONE;
        end
        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign HI   = hi_reg;
  assign LO   = lo_reg;
`ifdef MULDIV_DIV_EN
  assign div_by_zero = dbz_reg;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule
